// File: rtl/rrq_reader.sv
// rrq_reader: consumer side of the read-request grant handshake.
// Frames up to BURST_LEN popped words between a header and a trailer.
module rrq_reader #(
    parameter int TOTAL_APPS   = 8,
    parameter int APP_ID_WIDTH = 3,
    parameter int DATA_WIDTH   = 48,
    parameter int BURST_LEN    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             read_queue,
    input  logic [APP_ID_WIDTH-1:0]          app_id,
    output logic                             read_done,
    input  logic [TOTAL_APPS-1:0]            data_queue_empty,
    output logic [TOTAL_APPS-1:0]            data_queue_rd_en,
    input  logic [TOTAL_APPS*DATA_WIDTH-1:0] data_queue_rdata,
    output logic                             tx_valid,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_last,
    input  logic                             tx_ready
);

    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        WAIT,
        SEND,
        TRAILER,
        DONE,
        GAP
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [APP_ID_WIDTH-1:0] cur_id;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   data_q;

    logic                    in_range;
    logic                    sel_empty;
    logic                    burst_full;
    logic                    fetch_go;
    logic [DATA_WIDTH-1:0]   hdr_word;
    logic [DATA_WIDTH-1:0]   trl_word;

    // Pop decision is taken in FETCH only; an out-of-range id reads as empty.
    always_comb begin
        in_range   = 32'(cur_id) < 32'(TOTAL_APPS);
        sel_empty  = 1'b1;
        if (in_range) begin
            sel_empty = data_queue_empty[cur_id];
        end
        burst_full = (cnt == CW'(BURST_LEN));
        fetch_go   = (state == FETCH) && in_range && !sel_empty && !burst_full;
    end

    always_comb begin
        data_queue_rd_en = '0;
        if (fetch_go) begin
            data_queue_rd_en[cur_id] = 1'b1;
        end
    end

    always_comb begin
        hdr_word                        = '0;
        hdr_word[DATA_WIDTH-1 -: 8]     = 8'hA5;
        hdr_word[APP_ID_WIDTH-1:0]      = cur_id;
        trl_word                        = '0;
        trl_word[DATA_WIDTH-1 -: 8]     = 8'h5A;
        trl_word[CW-1:0]                = cnt;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (read_queue) state_nx = HEADER;
            HEADER:  if (tx_ready) state_nx = FETCH;
            FETCH:   state_nx = fetch_go ? WAIT : TRAILER;
            WAIT:    state_nx = SEND;
            SEND:    if (tx_ready) state_nx = FETCH;
            TRAILER: if (tx_ready) state_nx = DONE;
            DONE:    state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cur_id <= '0;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && read_queue) begin
                cur_id <= app_id;
                cnt    <= '0;
            end
            if (state == WAIT) begin
                data_q <= data_queue_rdata[cur_id*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == SEND && tx_ready) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Stream outputs decode from registered state, so they hold while stalled.
    always_comb begin
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        tx_data   = '0;
        read_done = (state == DONE);
        unique case (state)
            HEADER: begin
                tx_valid = 1'b1;
                tx_data  = hdr_word;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = data_q;
            end
            TRAILER: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = trl_word;
            end
            default: ;
        endcase
    end

endmodule
